// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg: shared load-type encodings and FIFO entry layout for writeback_unit.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_entry_t;

endpackage

`default_nettype wire

// File: rtl/writeback_unit_load_align.sv
// ----------------------------------------------------------------------------
// load_align: little-endian lane select and sign/zero extension of load data.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_align
  import wb_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] mem_rdata,
  input  logic [2:0]   funct3,
  input  logic [1:0]   off,
  output logic [n-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  if (n < 32) begin : g_bad_width
    $error("load_align: n must be at least 32");
  end

  always_comb begin
    lane_b = mem_rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      LB:      result = {{(n-8){lane_b[7]}}, lane_b};
      LBU:     result = {{(n-8){1'b0}}, lane_b};
      LH:      result = {{(n-16){lane_h[15]}}, lane_h};
      LHU:     result = {{(n-16){1'b0}}, lane_h};
      default: result = mem_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ----------------------------------------------------------------------------
// writeback_unit: register-file write port shared by ALU and load results,
// with load FIFO, busy scoreboard and optional WB_STARVE_GUARD_EN. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module writeback_unit
  import wb_pkg::*;
#(
  parameter int n        = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [n-1:0] alu_data,
  output logic         alu_stall,
  input  logic         ld_issue,
  input  logic [4:0]   ld_rd,
  input  logic [2:0]   ld_funct3,
  input  logic [1:0]   ld_off,
  output logic         ld_ready,
  input  logic         mem_rvalid,
  input  logic [n-1:0] mem_rdata,
  output logic         mem_rready,
  output logic         regw,
  output logic [4:0]   waddr,
  output logic [n-1:0] wdata,
  output logic [31:0]  busy
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("writeback_unit: DEPTH must be a power of two >= 2");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("writeback_unit: MAX_WAIT must be >= 1");
  end

  ld_entry_t       fifo [DEPTH];
  ld_entry_t       head;
  ld_entry_t       new_entry;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [PW-1:0]   slot_off;

  logic            hold_valid;
  logic [4:0]      hold_rd;
  logic [n-1:0]    hold_data;

  logic            push;
  logic            pop;
  logic            hold_prio;
  logic            hold_wr;
  logic            alu_acc;
  logic [n-1:0]    aligned;
  logic [31:0]     busy_d;

  assign head      = fifo[rd_ptr];
  assign new_entry = {ld_rd, ld_funct3, ld_off};
  assign ld_ready  = (count != (PW+1)'(DEPTH));
  assign push      = ld_issue && ld_ready;
  assign pop       = mem_rvalid && mem_rready && (count != '0);

  load_align #(.n(n)) u_align (
    .mem_rdata (mem_rdata),
    .funct3    (head.funct3),
    .off       (head.off),
    .result    (aligned)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!hold_valid || hold_wr) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign hold_prio = hold_valid && (wait_cnt == WW'(MAX_WAIT));
`else
  assign hold_prio = 1'b0;
`endif

  // hold_wr and alu_acc are mutually exclusive; rd==0 consumes without writing
  always_comb begin
    alu_acc   = alu_valid && !hold_prio;
    hold_wr   = hold_prio || (hold_valid && !alu_valid);
    alu_stall = alu_valid && hold_prio;
    regw      = 1'b0;
    waddr     = '0;
    wdata     = '0;
    if (hold_wr) begin
      if (hold_rd != 5'd0) begin
        regw  = 1'b1;
        waddr = hold_rd;
        wdata = hold_data;
      end
    end else if (alu_acc && alu_rd != 5'd0) begin
      regw  = 1'b1;
      waddr = alu_rd;
      wdata = alu_data;
    end
  end

  assign mem_rready = !hold_valid || hold_wr;

  // Busy is rebuilt from everything still outstanding after this edge
  always_comb begin
    busy_d   = '0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr;
      if (({1'b0, slot_off} < count) && !(pop && slot_off == '0)) begin
        busy_d[fifo[i].rd] = 1'b1;
      end
    end
    if (push) begin
      busy_d[ld_rd] = 1'b1;
    end
    if (pop) begin
      busy_d[head.rd] = 1'b1;
    end else if (hold_valid && !hold_wr) begin
      busy_d[hold_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      busy       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        hold_valid <= 1'b1;
        hold_rd    <= head.rd;
        hold_data  <= aligned;
      end else if (hold_wr) begin
        hold_valid <= 1'b0;
      end
      busy <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ----------------------------------------------------------------------------
// tb_writeback_unit: directed stimulus with a write-port scoreboard monitor.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_writeback_unit;
  import wb_pkg::*;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        regw;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  always #5 clock = ~clock;

  writeback_unit #(.n(32), .DEPTH(4), .MAX_WAIT(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off),
    .ld_ready(ld_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rready(mem_rready), .regw(regw), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  // Scoreboard: every presented write must match the oldest expected write
  always @(negedge clock) begin : mon
    wr_t e;
    if (mon_en) begin
      if (regw !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {59'd0, waddr}, {59'd0, e.a});
          chk("wr_data", {32'd0, wdata}, {32'd0, e.d});
        end
      end else begin
        chk("idle_zero", {27'd0, waddr, wdata}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_off = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] raw, input logic [31:0] want, input string nm);
    ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_off = off;
    mid(); tick();
    ld_issue = 1'b0; mem_rvalid = 1'b1; mem_rdata = raw;
    if (rd != 5'd0) push_exp(rd, want);
    mid();
    chk({nm, "_busy_set"}, {63'd0, busy[rd]}, {63'd0, rd != 5'd0});
    chk({nm, "_rready"}, {63'd0, mem_rready}, 64'd1);
    tick();
    mem_rvalid = 1'b0;
    mid();
    chk({nm, "_busy_during_wr"}, {63'd0, busy[rd]}, {63'd0, rd != 5'd0});
    tick();
    mid();
    chk({nm, "_busy_clr"}, {63'd0, busy[rd]}, 64'd0);
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] adata;
    bit          hold_turn;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    mid();
    chk("rst_alu_stall", {63'd0, alu_stall}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_mem_rready", {63'd0, mem_rready}, 64'd1);
    chk("rst_busy", {32'd0, busy}, 64'd0);
    tick();

    // ALU path, including rd 0
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    push_exp(5'd5, 32'h1234);
    mid(); chk("alu_stall_idle", {63'd0, alu_stall}, 64'd0); tick();
    alu_rd = 5'd0; alu_data = 32'hDEAD;
    mid(); chk("alu_rd0_stall", {63'd0, alu_stall}, 64'd0); tick();
    idle();

    // Load extension
    do_load(5'd7, LB,     2'd2, 32'h0080FF00, 32'hFFFFFF80, "lb_off2");
    do_load(5'd7, LBU,    2'd2, 32'h0080FF00, 32'h00000080, "lbu_off2");
    do_load(5'd8, LH,     2'd2, 32'h0080FF00, 32'h00000080, "lh_off2");
    do_load(5'd8, LHU,    2'd0, 32'h0080FF00, 32'h0000FF00, "lhu_off0");
    do_load(5'd9, LH,     2'd0, 32'h0080FF00, 32'hFFFFFF00, "lh_off0");
    do_load(5'd9, LB,     2'd1, 32'h0080FF00, 32'hFFFFFFFF, "lb_off1");
    do_load(5'd6, LW,     2'd3, 32'h0080FF00, 32'h0080FF00, "lw");
    do_load(5'd6, 3'b011, 2'd0, 32'h12345678, 32'h12345678, "f3_other");
    do_load(5'd0, LW,     2'd0, 32'hCAFEF00D, 32'h0,        "lw_rd0");

    // Fill FIFO, then drain
    for (int i = 0; i < 4; i++) begin
      ld_issue = 1'b1; ld_rd = 5'(11 + i); ld_funct3 = LW; ld_off = 2'd0;
      mid(); chk("ld_ready_filling", {63'd0, ld_ready}, 64'd1); tick();
    end
    ld_issue = 1'b0;
    mid();
    chk("ld_ready_full", {63'd0, ld_ready}, 64'd0);
    chk("busy_full", {32'd0, busy}, 64'h0000_0000_0000_7800);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h11; push_exp(5'd11, 32'h11);
    mid(); chk("ld_ready_pop_same", {63'd0, ld_ready}, 64'd0); tick();
    mem_rdata = 32'h12; push_exp(5'd12, 32'h12);
    mid(); chk("ld_ready_after_pop", {63'd0, ld_ready}, 64'd1);
    chk("rready_refill", {63'd0, mem_rready}, 64'd1); tick();
    mem_rdata = 32'h13; push_exp(5'd13, 32'h13);
    mid(); tick();
    mem_rdata = 32'h14; push_exp(5'd14, 32'h14);
    mid(); tick();
    mem_rvalid = 1'b0;
    mid(); tick();
    mid(); chk("busy_drained", {32'd0, busy}, 64'd0); tick();

    // Streamed loads to exercise pointer wrap
    for (int i = 0; i <= 10; i++) begin
      ld_issue = (i < 10); ld_rd = 5'(16 + i); ld_funct3 = LW; ld_off = 2'd0;
      mem_rvalid = (i > 0); mem_rdata = 32'(32'h100 + i - 1);
      if (i > 0) push_exp(5'(16 + i - 1), 32'(32'h100 + i - 1));
      mid(); chk("stream_rready", {63'd0, mem_rready}, 64'd1); tick();
    end
    idle();
    mid(); tick();

    // Stray response with FIFO empty
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    mid(); tick();
    mem_rvalid = 1'b0;
    mid(); chk("stray_busy", {32'd0, busy}, 64'd0); tick();

    // Held load against continuous ALU traffic
    ld_issue = 1'b1; ld_rd = 5'd9; ld_funct3 = LW; ld_off = 2'd0;
    mid(); tick();
    ld_issue = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    mid(); tick();
    mem_rvalid = 1'b0;
    adata = 32'h1000; alu_valid = 1'b1; alu_rd = 5'd10;
    for (int k = 0; k < 6; k++) begin
      alu_data  = adata;
      hold_turn = GUARD && (k == 3);
      if (hold_turn) push_exp(5'd9, 32'hAAAA5555);
      else           push_exp(5'd10, adata);
      mid();
      chk("starve_alu_stall", {63'd0, alu_stall}, {63'd0, hold_turn});
      chk("starve_rready", {63'd0, mem_rready}, {63'd0, hold_turn || (GUARD && k > 3)});
      tick();
      if (!hold_turn) adata = adata + 32'd1;
    end
    alu_valid = 1'b0;
    if (!GUARD) push_exp(5'd9, 32'hAAAA5555);
    mid(); chk("starve_release_rready", {63'd0, mem_rready}, 64'd1); tick();
    mid(); chk("starve_busy_clr", {63'd0, busy[9]}, 64'd0); tick();

    // Two outstanding loads to the same register
    ld_issue = 1'b1; ld_rd = 5'd3; ld_funct3 = LW; ld_off = 2'd0;
    mid(); tick();
    mid(); tick();
    ld_issue = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33; push_exp(5'd3, 32'h33);
    mid(); tick();
    mem_rvalid = 1'b0;
    mid(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h34; push_exp(5'd3, 32'h34);
    mid(); chk("busy3_after_first", {63'd0, busy[3]}, 64'd1); tick();
    mem_rvalid = 1'b0;
    mid(); tick();
    mid(); chk("busy3_after_second", {63'd0, busy[3]}, 64'd0); tick();

    // Reset with loads pending and hold occupied
    for (int i = 0; i < 3; i++) begin
      ld_issue = 1'b1; ld_rd = 5'(20 + i); ld_funct3 = LW; ld_off = 2'd0;
      mid(); tick();
    end
    ld_issue = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; alu_valid = 1'b1; alu_rd = 5'd0;
    mid(); tick();
    mem_rvalid = 1'b0; reset = 1'b1;
    mid(); chk("busy_before_reset", {32'd0, busy}, 64'h0000_0000_0070_0000); tick();
    reset = 1'b0; idle();
    mid();
    chk("post_rst_busy", {32'd0, busy}, 64'd0);
    chk("post_rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("post_rst_rready", {63'd0, mem_rready}, 64'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    mid(); tick();
    mem_rvalid = 1'b0;
    mid();
    chk("post_rst_stray_busy", {32'd0, busy}, 64'd0);
    chk("post_rst_stray_ready", {63'd0, ld_ready}, 64'd1);
    tick();
    mid(); tick();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Drives the single register-file write port (clock, regw, waddr, wdata) from two producers: single-cycle ALU results and in-order, variable-latency data-memory load responses. Tracks outstanding loads in a small FIFO, aligns and sign/zero-extends returned load data, and arbitrates the write port with a starvation guard. Exports a per-register busy scoreboard for the issue stage. Sits between execute/memory and the register file.

## Interface
- n, 32, data width
- DEPTH, 4, outstanding-load FIFO entries (power of two, ≥2)
- MAX_WAIT, 3, cycles a held load may lose arbitration before it takes priority
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  n  ALU result
- alu_stall  out  1  ALU result not accepted this cycle; upstream holds alu_* stable
- ld_issue  in  1  load issued to memory; legal only when ld_ready
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (RV32I encoding)
- ld_off  in  2  address bits [1:0]
- ld_ready  out  1  FIFO not full
- mem_rvalid  in  1  load data valid
- mem_rdata  in  n  raw aligned word from memory
- mem_rready  out  1  unit accepts load data this cycle
- regw  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  n  register-file write data
- busy  out  32  bit r set while a load to r is outstanding

## Operation
- Load FIFO entry {rd, funct3, off}; pushed on ld_issue, popped on mem_rvalid && mem_rready. Responses are in issue order.
- Popped response is extended and stored in hold register (hold_valid, hold_rd, hold_data).
- Extension: 000 LB, 001 LH, 100 LBU, 101 LHU select byte lane off / halfword lane off[1] (little-endian), sign/zero-extend to n; 010 LW and all other codes pass word unchanged.
- Arbitration each cycle: if hold_valid && wait_cnt==MAX_WAIT → hold writes, alu_stall=alu_valid. Else if alu_valid → ALU writes, alu_stall=0. Else if hold_valid → hold writes.
- wait_cnt: increments while hold_valid and hold not written; clears when hold written. Saturates at MAX_WAIT.
- rd==0: regw stays 0, but the result is still consumed (ALU accepted, hold cleared, busy unaffected).
- mem_rready = !hold_valid || hold written this cycle (hold refills same edge).
- mem_rvalid with FIFO empty: ignored, no state change.
- busy[r] set at the edge after ld_issue with ld_rd=r≠0; cleared at the edge where hold for r is retired, unless another FIFO entry (including one pushed that edge) still targets r. busy[0] always 0.
- When regw=0: waddr=0, wdata=0.

## Timing
- Reset values: regw 0, waddr 0, wdata 0, alu_stall 0, ld_ready 1, mem_rready 1, busy 0; FIFO empty, hold_valid 0, wait_cnt 0. Reset mid-operation discards all pending loads.
- regw/waddr/wdata/alu_stall/mem_rready combinational from registered state and current inputs.
- ALU latency 0: regw asserted same cycle, register updated at next edge.
- Load latency: response accepted at edge t → regw earliest in cycle t+1.
- ld_ready = !full from registered count; a pop in the same cycle does not raise ld_ready until next cycle. Push and pop same cycle: count unchanged.
- Pointers wrap modulo DEPTH.

## Configuration
- WB_STARVE_GUARD_EN defined: MAX_WAIT priority rule active as above.
- Undefined: ALU always wins; alu_stall tied 0; wait_cnt not built; held load waits for an ALU-idle cycle.

## Structure
- Package wb_pkg: funct3 constants (LB, LH, LW, LBU, LHU), ld_entry_t struct {rd, funct3, off}.
- Sub-module load_align: combinational lane select and extension (mem_rdata, funct3, off → n-bit result).
- FIFO and scoreboard inline.

## Test plan
- Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 → regw=1, waddr=5, wdata=0x1234 same cycle; alu_rd=0 → regw=0.
- ld_issue rd=7 funct3=000 off=2; mem_rdata=0x0080FF00 → busy[7]=1 until write; wdata=0xFFFFFF80; LBU → 0x00000080; LH off=2 → 0x00000080.
- Issue 4 loads → ld_ready=0; 5th attempt absent; one response → ld_ready=1 next cycle; pointers wrap across 10 loads with correct rd order.
- Held load, alu_valid continuous with guard on → hold writes in 4th cycle with alu_stall=1; guard off → waits until alu_valid=0.
- Two loads to rd=3 outstanding → busy[3] stays 1 after first retires, clears after second.
- Reset asserted with 2 loads pending and hold_valid → next cycle busy=0, ld_ready=1, regw=0; stray mem_rvalid ignored.
